// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the handshaked data memory.
//   dmem_state_t  - controller states (IDLE, WAIT_ST, RESP)
//   clog2         - ceiling log2 usable in constant expressions
//   byte_lanes    - number of byte lanes in an N-bit word
//   index_width   - width of the word-index field for a given depth (min 1)
//   INIT_WORDS / init_word - power-up image of the storage array
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_ST = 2'd1,
        RESP    = 2'd2
    } dmem_state_t;

    localparam int INIT_WORDS = 12;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int byte_lanes(input int width);
        return width / 8;
    endfunction

    function automatic int index_width(input int depth);
        return (clog2(depth) > 0) ? clog2(depth) : 1;
    endfunction

    // Words 0..11 repeat the sequence 1..6; everything above is zero.
    function automatic logic [31:0] init_word(input int idx);
        logic [31:0] value;
        case (idx)
            0, 6:    value = 32'd1;
            1, 7:    value = 32'd2;
            2, 8:    value = 32'd3;
            3, 9:    value = 32'd4;
            4, 10:   value = 32'd5;
            5, 11:   value = 32'd6;
            default: value = 32'd0;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: Depth x N word storage.
//   clk      - clock
//   reset    - synchronous active-high; clears only the read register
//   wr_en    - commit wr_data into word wr_idx on this edge
//   wr_idx   - word index for the write
//   wr_be    - per-byte write enables
//   wr_data  - write data
//   rd_en    - load rd_data from word rd_idx on this edge; otherwise rd_data clears
//   rd_idx   - word index for the read
//   rd_data  - registered read data (zero unless loaded on the previous edge)
// Storage is not affected by reset and powers up holding the package image.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int N     = 32,
    parameter int Depth = 32,
    parameter int IW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic [N/8-1:0]   wr_be,
    input  logic [N-1:0]     wr_data,
    input  logic             rd_en,
    input  logic [IW-1:0]    rd_idx,
    output logic [N-1:0]     rd_data
);

    localparam int LANES = byte_lanes(N);

    logic [N-1:0] words_s [Depth];
    logic [N-1:0] rd_data_r;

    for (genvar w = 0; w < Depth; w++) begin : g_word
        logic [N-1:0] word_r = N'(init_word(w));
        logic         hit_s;

        assign hit_s = wr_en && (wr_idx == IW'(w));

        // Byte-lane write: lanes whose enable is clear keep their contents.
        always_ff @(posedge clk) begin
            for (int b = 0; b < LANES; b++) begin
                if (hit_s && wr_be[b]) begin
                    word_r[8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end

        assign words_s[w] = word_r;
    end

    // Registered read port; clears whenever no read is requested so the
    // top can drive it straight onto data_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r <= '0;
        end else if (rd_en && (int'(rd_idx) < Depth)) begin
            rd_data_r <= words_s[rd_idx];
        end else begin
            rd_data_r <= '0;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/data_mem_hs.sv
// data_mem_hs: handshaked, byte-addressed data memory with wait states.
//   clk      - clock
//   reset    - synchronous active-high reset (aborts any transaction)
//   req      - request strobe, sampled only while ready=1
//   we       - 1 = write, 0 = read (sampled with req)
//   address  - byte address
//   be       - byte enables for writes
//   data_in  - write data
//   ready    - idle and able to accept a request
//   done     - one-cycle response pulse
//   data_out - read data while done=1 for a read, zero otherwise
//   err      - with done: misaligned or out-of-range access
module data_mem_hs
    import dmem_pkg::*;
#(
    parameter int N     = 32,
    parameter int Depth = 32,
    parameter int WAIT  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             we,
    input  logic [N-1:0]     address,
    input  logic [N/8-1:0]   be,
    input  logic [N-1:0]     data_in,
    output logic             ready,
    output logic             done,
    output logic [N-1:0]     data_out,
    output logic             err
);

    localparam int              LANES     = byte_lanes(N);
    localparam int              OFF_W     = clog2(LANES);
    localparam int              IW        = index_width(Depth);
    localparam int              CW        = (clog2(WAIT + 1) > 0) ? clog2(WAIT + 1) : 1;
    localparam bit              NO_WAIT   = (WAIT == 0);
    localparam logic [CW-1:0]   CNT_LOAD  = NO_WAIT ? CW'(0) : CW'(WAIT - 1);
    localparam logic [N-1:0]    OFF_MASK  = N'(LANES - 1);
    localparam logic [IW:0]     DEPTH_LIM = (IW + 1)'(Depth);

    dmem_state_t       state_r;
    dmem_state_t       state_next_s;
    logic              accept_s;
    logic [CW-1:0]     cnt_r;

    logic              we_r;
    logic [N-1:0]      addr_r;
    logic [N/8-1:0]    be_r;
    logic [N-1:0]      data_r;

    logic [N-1:0]      sel_addr_s;
    logic              sel_we_s;
    logic [IW-1:0]     sel_idx_s;
    logic              bad_s;

    logic              ready_r;
    logic              done_r;
    logic              err_r;
    logic              rd_en_s;
    logic              wr_en_s;
    logic [N-1:0]      rd_data_s;

    // Request seen by the checker and array: live inputs while idle (needed
    // when WAIT=0 goes straight to RESP), the captured copy otherwise.
    always_comb begin
        sel_addr_s = addr_r;
        sel_we_s   = we_r;
        if (state_r == IDLE) begin
            sel_addr_s = address;
            sel_we_s   = we;
        end else begin
            sel_addr_s = addr_r;
            sel_we_s   = we_r;
        end
    end

    // Word index and error classification; the bits above the index field
    // must be clear so no out-of-range address can alias a real word.
    always_comb begin
        sel_idx_s = IW'(sel_addr_s >> OFF_W);
        bad_s     = ((sel_addr_s & OFF_MASK) != '0)
                 || ((sel_addr_s >> (OFF_W + IW)) != '0)
                 || ({1'b0, sel_idx_s} >= DEPTH_LIM);
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req) begin
                    accept_s     = 1'b1;
                    state_next_s = NO_WAIT ? RESP : WAIT_ST;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT_ST: begin
                if (cnt_r == '0) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT_ST;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Wait-state counter: loaded at acceptance, counts down in WAIT_ST.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (accept_s) begin
            cnt_r <= CNT_LOAD;
        end else if ((state_r == WAIT_ST) && (cnt_r != '0)) begin
            cnt_r <= cnt_r - CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Request capture so the inputs may change after acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_r   <= 1'b0;
            addr_r <= '0;
            be_r   <= '0;
            data_r <= '0;
        end else if (accept_s) begin
            we_r   <= we;
            addr_r <= address;
            be_r   <= be;
            data_r <= data_in;
        end else begin
            we_r   <= we_r;
            addr_r <= addr_r;
            be_r   <= be_r;
            data_r <= data_r;
        end
    end

    // Handshake outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            ready_r <= (state_next_s == IDLE);
            done_r  <= (state_next_s == RESP);
            err_r   <= (state_next_s == RESP) && bad_s;
        end
    end

    // The read is taken on the edge entering RESP; the write commits on the
    // edge leaving RESP, so a following request always sees it.
    assign rd_en_s = (state_next_s == RESP) && !sel_we_s && !bad_s && !reset;
    assign wr_en_s = (state_r == RESP) && we_r && !bad_s && !reset;

    dmem_array #(
        .N     (N),
        .Depth (Depth),
        .IW    (IW)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en_s),
        .wr_idx  (sel_idx_s),
        .wr_be   (be_r),
        .wr_data (data_r),
        .rd_en   (rd_en_s),
        .rd_idx  (sel_idx_s),
        .rd_data (rd_data_s)
    );

    assign ready    = ready_r;
    assign done     = done_r;
    assign err      = err_r;
    assign data_out = rd_data_s;

endmodule
